// File: rtl/rs_issue_buffer.sv
// Reservation-station entry bank: holds dispatched ops, wakes sources from the CDB,
// presents ready requests plus PCs to the age selector and registers the granted entry.
module rs_issue_buffer #(
  parameter int RS_SIZE = 16,
  parameter int TAG_W   = 6,
  parameter int XLEN    = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              alloc_valid,
  input  logic [XLEN-1:0]                   alloc_pc,
  input  logic [TAG_W-1:0]                  alloc_dest_tag,
  input  logic [TAG_W-1:0]                  alloc_src1_tag,
  input  logic                              alloc_src1_rdy,
  input  logic [TAG_W-1:0]                  alloc_src2_tag,
  input  logic                              alloc_src2_rdy,
  output logic                              alloc_ready,
  input  logic                              cdb_valid,
  input  logic [TAG_W-1:0]                  cdb_tag,
  output logic [RS_SIZE-1:0]                sel_req,
  output logic [RS_SIZE-1:0][XLEN-1:0]      sel_pc,
  input  logic [RS_SIZE-1:0]                sel_gnt,
  input  logic                              squash,
  output logic                              issue_valid,
  output logic [XLEN-1:0]                   issue_pc,
  output logic [TAG_W-1:0]                  issue_dest_tag,
  output logic [$clog2(RS_SIZE+1)-1:0]      free_count
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = $clog2(RS_SIZE+1);

  logic [RS_SIZE-1:0]             valid_vec;
  logic [RS_SIZE-1:0][TAG_W-1:0]  dest_vec;
  logic [RS_SIZE-1:0]             masked_gnt;
  logic                           gnt_one;
  logic [IDX_W-1:0]               alloc_idx;
  logic                           alloc_fire;
  logic                           src1_bypass;
  logic                           src2_bypass;
  logic [XLEN-1:0]                gnt_pc;
  logic [TAG_W-1:0]               gnt_dest;
  logic [CNT_W-1:0]               free_cnt;

  // Only a single surviving grant bit retires an entry; multi-hot retires nothing.
  assign masked_gnt = sel_gnt & sel_req;
  assign gnt_one    = (masked_gnt != '0) && ((masked_gnt & (masked_gnt - 1'b1)) == '0);

  assign alloc_ready = |(~valid_vec);
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign free_count  = free_cnt;

  // A source broadcast in the dispatch cycle is captured as already ready.
  assign src1_bypass = cdb_valid && (cdb_tag == alloc_src1_tag);
  assign src2_bypass = cdb_valid && (cdb_tag == alloc_src2_tag);

  always_comb begin
    alloc_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid_vec[i]) alloc_idx = IDX_W'(i);
    end
  end

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      free_cnt = free_cnt + CNT_W'(~valid_vec[i]);
    end
  end

  // OR-mux is exact because the result is only consumed when the grant is one-hot.
  always_comb begin
    gnt_pc   = '0;
    gnt_dest = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (masked_gnt[i]) begin
        gnt_pc   = gnt_pc | sel_pc[i];
        gnt_dest = gnt_dest | dest_vec[i];
      end
    end
  end

  for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
    logic             valid_reg;
    logic             src1_rdy_reg;
    logic             src2_rdy_reg;
    logic [XLEN-1:0]  pc_reg;
    logic [TAG_W-1:0] dest_reg;
    logic [TAG_W-1:0] src1_tag_reg;
    logic [TAG_W-1:0] src2_tag_reg;
    logic             alloc_hit;
    logic             issue_hit;

    assign alloc_hit = alloc_fire && (alloc_idx == IDX_W'(gi));
    assign issue_hit = gnt_one && masked_gnt[gi];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        valid_reg    <= 1'b0;
        src1_rdy_reg <= 1'b0;
        src2_rdy_reg <= 1'b0;
        pc_reg       <= '0;
        dest_reg     <= '0;
        src1_tag_reg <= '0;
        src2_tag_reg <= '0;
      end else if (squash) begin
        valid_reg <= 1'b0;
      end else if (alloc_hit) begin
        valid_reg    <= 1'b1;
        pc_reg       <= alloc_pc;
        dest_reg     <= alloc_dest_tag;
        src1_tag_reg <= alloc_src1_tag;
        src2_tag_reg <= alloc_src2_tag;
        src1_rdy_reg <= alloc_src1_rdy | src1_bypass;
        src2_rdy_reg <= alloc_src2_rdy | src2_bypass;
      end else begin
        if (issue_hit) valid_reg <= 1'b0;
        if (cdb_valid && valid_reg && (cdb_tag == src1_tag_reg)) src1_rdy_reg <= 1'b1;
        if (cdb_valid && valid_reg && (cdb_tag == src2_tag_reg)) src2_rdy_reg <= 1'b1;
      end
    end

    assign valid_vec[gi] = valid_reg;
    assign sel_req[gi]   = valid_reg & src1_rdy_reg & src2_rdy_reg;
    assign sel_pc[gi]    = pc_reg;
    assign dest_vec[gi]  = dest_reg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issue_valid    <= 1'b0;
      issue_pc       <= '0;
      issue_dest_tag <= '0;
    end else if (squash) begin
      issue_valid <= 1'b0;
    end else if (gnt_one) begin
      issue_valid    <= 1'b1;
      issue_pc       <= gnt_pc;
      issue_dest_tag <= gnt_dest;
    end else begin
      issue_valid <= 1'b0;
    end
  end

  // The selector must never grant more than one entry per cycle.
  always @(posedge clock) begin
    if (!reset && !squash) begin
      assert ($onehot0(sel_gnt))
        else $warning("rs_issue_buffer: illegal multi-hot sel_gnt %b", sel_gnt);
    end
  end

endmodule

// File: tb/tb_rs_issue_buffer.sv
// Bench for rs_issue_buffer: directed scenarios plus randomized traffic, all checked
// against an entry-table reference model.
module tb_rs_issue_buffer;
  localparam int RS = 16;
  localparam int TW = 6;
  localparam int XL = 32;
  localparam int CW = $clog2(RS+1);

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  alloc_valid;
  logic [XL-1:0]         alloc_pc;
  logic [TW-1:0]         alloc_dest_tag;
  logic [TW-1:0]         alloc_src1_tag;
  logic                  alloc_src1_rdy;
  logic [TW-1:0]         alloc_src2_tag;
  logic                  alloc_src2_rdy;
  logic                  alloc_ready;
  logic                  cdb_valid;
  logic [TW-1:0]         cdb_tag;
  logic [RS-1:0]         sel_req;
  logic [RS-1:0][XL-1:0] sel_pc;
  logic [RS-1:0]         sel_gnt;
  logic                  squash;
  logic                  issue_valid;
  logic [XL-1:0]         issue_pc;
  logic [TW-1:0]         issue_dest_tag;
  logic [CW-1:0]         free_count;

  always #5 clock = ~clock;

  rs_issue_buffer #(.RS_SIZE(RS), .TAG_W(TW), .XLEN(XL)) dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_dest_tag(alloc_dest_tag),
    .alloc_src1_tag(alloc_src1_tag), .alloc_src1_rdy(alloc_src1_rdy),
    .alloc_src2_tag(alloc_src2_tag), .alloc_src2_rdy(alloc_src2_rdy),
    .alloc_ready(alloc_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .sel_req(sel_req), .sel_pc(sel_pc), .sel_gnt(sel_gnt), .squash(squash),
    .issue_valid(issue_valid), .issue_pc(issue_pc), .issue_dest_tag(issue_dest_tag),
    .free_count(free_count)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a table of instructions plus the last issue packet.
  bit            m_valid [RS];
  logic [XL-1:0] m_pc    [RS];
  logic [TW-1:0] m_dest  [RS];
  logic [TW-1:0] m_t1    [RS];
  logic [TW-1:0] m_t2    [RS];
  bit            m_r1    [RS];
  bit            m_r2    [RS];
  bit            m_iv;
  logic [XL-1:0] m_ipc;
  logic [TW-1:0] m_idest;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready(input int i);
    return m_valid[i] && m_r1[i] && m_r2[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < RS; i++) begin
      m_valid[i] = 0; m_r1[i] = 0; m_r2[i] = 0;
    end
    m_iv = 0; m_ipc = '0; m_idest = '0;
  endtask

  task automatic model_step();
    int nfree;
    int aidx;
    int nhot;
    int k;
    bit req [RS];
    nfree = 0; aidx = -1; nhot = 0; k = -1;
    for (int i = 0; i < RS; i++) begin
      req[i] = m_ready(i);
      if (!m_valid[i]) begin
        nfree++;
        if (aidx < 0) aidx = i;
      end
    end
    if (squash) begin
      for (int i = 0; i < RS; i++) m_valid[i] = 0;
      m_iv = 0;
    end else begin
      for (int i = 0; i < RS; i++) begin
        if (sel_gnt[i] && req[i]) begin
          nhot++;
          k = i;
        end
      end
      if (nhot == 1) begin
        m_iv = 1; m_ipc = m_pc[k]; m_idest = m_dest[k];
      end else begin
        m_iv = 0;
      end
      if (cdb_valid) begin
        for (int i = 0; i < RS; i++) begin
          if (m_valid[i] && m_t1[i] == cdb_tag) m_r1[i] = 1;
          if (m_valid[i] && m_t2[i] == cdb_tag) m_r2[i] = 1;
        end
      end
      if (nhot == 1) m_valid[k] = 0;
      if (alloc_valid && nfree > 0) begin
        m_valid[aidx] = 1;
        m_pc[aidx]    = alloc_pc;
        m_dest[aidx]  = alloc_dest_tag;
        m_t1[aidx]    = alloc_src1_tag;
        m_t2[aidx]    = alloc_src2_tag;
        m_r1[aidx]    = alloc_src1_rdy || (cdb_valid && cdb_tag == alloc_src1_tag);
        m_r2[aidx]    = alloc_src2_rdy || (cdb_valid && cdb_tag == alloc_src2_tag);
      end
    end
  endtask

  task automatic check_all();
    logic [RS-1:0] exp_req;
    int nfree;
    nfree = 0;
    for (int i = 0; i < RS; i++) begin
      exp_req[i] = m_ready(i);
      if (!m_valid[i]) nfree++;
    end
    check_val("sel_req", 64'(sel_req), 64'(exp_req));
    check_val("free_count", 64'(free_count), 64'(nfree));
    check_val("alloc_ready", 64'(alloc_ready), 64'(nfree > 0));
    check_val("issue_valid", 64'(issue_valid), 64'(m_iv));
    check_val("issue_pc", 64'(issue_pc), 64'(m_ipc));
    check_val("issue_dest_tag", 64'(issue_dest_tag), 64'(m_idest));
    for (int i = 0; i < RS; i++) begin
      if (m_valid[i]) check_val($sformatf("sel_pc[%0d]", i), 64'(sel_pc[i]), 64'(m_pc[i]));
    end
  endtask

  task automatic drive(input bit av, input logic [XL-1:0] apc, input logic [TW-1:0] ad,
                       input logic [TW-1:0] t1, input bit r1, input logic [TW-1:0] t2,
                       input bit r2, input bit cv, input logic [TW-1:0] ct,
                       input logic [RS-1:0] g, input bit sq);
    alloc_valid = av; alloc_pc = apc; alloc_dest_tag = ad;
    alloc_src1_tag = t1; alloc_src1_rdy = r1; alloc_src2_tag = t2; alloc_src2_rdy = r2;
    cdb_valid = cv; cdb_tag = ct; sel_gnt = g; squash = sq;
    model_step();
    $display("cyc %0d alloc=%0b pc=%0h cdb=%0b/%0d gnt=%04h squash=%0b", cyc, av, apc, cv, ct, g, sq);
    @(posedge clock);
    #1;
    check_all();
    cyc++;
  endtask

  initial begin
    int q[$];
    int r;
    logic [RS-1:0] g;

    reset = 1'b1;
    alloc_valid = 0; alloc_pc = '0; alloc_dest_tag = '0;
    alloc_src1_tag = '0; alloc_src1_rdy = 0; alloc_src2_tag = '0; alloc_src2_rdy = 0;
    cdb_valid = 0; cdb_tag = '0; sel_gnt = '0; squash = 0;
    model_reset();
    @(negedge clock);
    check_all();
    reset = 1'b0;

    // basic dispatch then issue
    drive(1, 32'h100, 6'd1, 6'd0, 1, 6'd0, 1, 0, 6'd0, 16'h0000, 0);
    check_val("t1_req0", 64'(sel_req[0]), 64'd1);
    drive(0, 32'h0, 6'd0, 6'd0, 0, 6'd0, 0, 0, 6'd0, 16'h0001, 0);
    check_val("t1_issue_valid", 64'(issue_valid), 64'd1);
    check_val("t1_issue_pc", 64'(issue_pc), 64'h100);

    // wakeup latency and same-cycle bypass
    drive(1, 32'h104, 6'd2, 6'd5, 0, 6'd7, 1, 0, 6'd0, 16'h0000, 0);
    check_val("t2_req_wait", 64'(sel_req[0]), 64'd0);
    drive(0, 32'h0, 6'd0, 6'd0, 0, 6'd0, 0, 1, 6'd5, 16'h0000, 0);
    check_val("t2_req_woken", 64'(sel_req[0]), 64'd1);
    drive(1, 32'h108, 6'd3, 6'd5, 0, 6'd5, 0, 1, 6'd5, 16'h0000, 0);
    check_val("t2_bypass_req", 64'(sel_req[1]), 64'd1);

    // fill, overflow, free one
    drive(0, 32'h0, 6'd0, 6'd0, 0, 6'd0, 0, 0, 6'd0, 16'h0000, 1);
    for (int i = 0; i < RS; i++)
      drive(1, 32'h200 + 32'(4 * i), 6'(i), 6'd0, 1, 6'd0, 1, 0, 6'd0, 16'h0000, 0);
    check_val("t3_full_count", 64'(free_count), 64'd0);
    check_val("t3_full_ready", 64'(alloc_ready), 64'd0);
    drive(1, 32'hdead, 6'd9, 6'd0, 1, 6'd0, 1, 0, 6'd0, 16'h0000, 0);
    check_val("t3_drop_count", 64'(free_count), 64'd0);
    drive(0, 32'h0, 6'd0, 6'd0, 0, 6'd0, 0, 0, 6'd0, 16'h0001, 0);
    check_val("t3_freed_one", 64'(free_count), 64'd1);

    // freed-by-grant slot is not reused in the same cycle
    drive(1, 32'h300, 6'd9, 6'd0, 1, 6'd0, 1, 0, 6'd0, 16'h0008, 0);
    check_val("t4_new_slot_pc", 64'(sel_pc[0]), 64'h300);
    check_val("t4_slot3_req", 64'(sel_req[3]), 64'd0);
    check_val("t4_issue_pc", 64'(issue_pc), 64'h20c);

    // illegal multi-hot grant, then grant to non-requesting entry
    drive(0, 32'h0, 6'd0, 6'd0, 0, 6'd0, 0, 0, 6'd0, 16'h0003, 0);
    check_val("t5_multi_issue", 64'(issue_valid), 64'd0);
    check_val("t5_multi_count", 64'(free_count), 64'd1);
    drive(1, 32'h400, 6'd10, 6'd20, 0, 6'd20, 0, 0, 6'd0, 16'h0000, 0);
    drive(0, 32'h0, 6'd0, 6'd0, 0, 6'd0, 0, 0, 6'd0, 16'h0008, 0);
    check_val("t5_nonreq_issue", 64'(issue_valid), 64'd0);

    // squash overrides everything in its cycle
    drive(1, 32'h500, 6'd1, 6'd20, 1, 6'd20, 1, 1, 6'd20, 16'h0001, 1);
    check_val("t6_count", 64'(free_count), 64'd16);
    check_val("t6_issue", 64'(issue_valid), 64'd0);
    check_val("t6_req", 64'(sel_req), 64'd0);

    // randomized traffic with a mid-run asynchronous reset
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        #2 reset = 1'b1;
        model_reset();
        #1 check_all();
        @(negedge clock);
        reset = 1'b0;
      end
      q.delete();
      for (int i = 0; i < RS; i++) if (m_ready(i)) q.push_back(i);
      g = '0;
      r = int'($urandom_range(0, 99));
      if (r < 70 && q.size() > 0) g[q[$urandom_range(0, q.size() - 1)]] = 1'b1;
      else if (r < 85) g[$urandom_range(0, RS - 1)] = 1'b1;
      drive($urandom_range(0, 9) < 6, $urandom, 6'($urandom_range(0, 63)),
            6'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            6'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, 6'($urandom_range(0, 7)), g,
            $urandom_range(0, 49) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
